// File: rtl/ic_gb8_color_convert.sv
// Packed RGB word stream (3 words -> 4 pixels) to signed, level-shifted JFIF YCbCr samples.
// Three register stages: unpack, products/sums, shift/saturate. Two lanes so p2 can emit 2 pixels.
module ic_gb8_color_convert #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 48,
  parameter int unsigned OUT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  GB8_outputready,
  input  logic [DATA_WIDTH-1:0] GB8_data,
  input  logic                  IC_frame_start,
  output logic                  CC_wren0,
  output logic [5:0]            CC_addr0,
  output logic [OUT_WIDTH-1:0]  CC_Y0,
  output logic [OUT_WIDTH-1:0]  CC_Cb0,
  output logic [OUT_WIDTH-1:0]  CC_Cr0,
  output logic                  CC_wren1,
  output logic [5:0]            CC_addr1,
  output logic [OUT_WIDTH-1:0]  CC_Y1,
  output logic [OUT_WIDTH-1:0]  CC_Cb1,
  output logic [OUT_WIDTH-1:0]  CC_Cr1,
  output logic                  CC_block_done,
  output logic [15:0]           CC_block_count
);

  localparam int unsigned AccW = 18;
  localparam logic [5:0] LastPx = 6'(BLOCK_WORDS * 4 / 3 - 1);
  localparam logic signed [AccW-1:0] SatMax = AccW'(2 ** (OUT_WIDTH - 1) - 1);
  localparam logic signed [AccW-1:0] SatMin = -SatMax - 18'sd1;

  typedef struct packed {logic [7:0] r, g, b;} rgb_t;
  typedef struct packed {logic signed [AccW-1:0] y, cb, cr;} acc_t;

  function automatic acc_t convert(input rgb_t p);
    logic signed [AccW-1:0] r, g, b;
    r = $signed({10'd0, p.r});
    g = $signed({10'd0, p.g});
    b = $signed({10'd0, p.b});
    convert.y  = 18'sd77 * r + 18'sd150 * g + 18'sd29 * b + 18'sd128;
    convert.cb = -18'sd43 * r - 18'sd85 * g + 18'sd128 * b + 18'sd128;
    convert.cr = 18'sd128 * r - 18'sd107 * g - 18'sd21 * b + 18'sd128;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] sat(input logic signed [AccW-1:0] v);
    if (v > SatMax) return SatMax[OUT_WIDTH-1:0];
    else if (v < SatMin) return SatMin[OUT_WIDTH-1:0];
    else return v[OUT_WIDTH-1:0];
  endfunction

  logic [1:0] phase_q, phase_d, ph;
  logic [5:0] idx_q, idx_d, ix;
  logic [7:0] hold_r_q, hold_r_d, hold_g_q, hold_g_d, hr, hg;
  logic [7:0] b3, b2, b1, b0;
  rgb_t       l0, l1;
  logic       v0, v1;

  logic       s1_v0, s1_v1, s1_done;
  logic [5:0] s1_a0, s1_a1;
  rgb_t       s1_p0, s1_p1;
  logic       s2_v0, s2_v1, s2_done;
  logic [5:0] s2_a0, s2_a1;
  acc_t       s2_c0, s2_c1;

  // Frame start realigns the word being accepted this cycle, not just the next one.
  always_comb begin
    ph = IC_frame_start ? 2'd0 : phase_q;
    ix = IC_frame_start ? 6'd0 : idx_q;
    hr = IC_frame_start ? 8'd0 : hold_r_q;
    hg = IC_frame_start ? 8'd0 : hold_g_q;
    {b3, b2, b1, b0} = GB8_data[31:0];
    l0 = '0;
    l1 = '0;
    v0 = 1'b0;
    v1 = 1'b0;
    phase_d  = ph;
    idx_d    = ix;
    hold_r_d = hr;
    hold_g_d = hg;
    if (GB8_outputready) begin
      v0 = 1'b1;
      case (ph)
        2'd0: begin
          l0 = '{r: b3, g: b2, b: b1};
          hold_r_d = b0;
          phase_d  = 2'd1;
          idx_d    = ix + 6'd1;
        end
        2'd1: begin
          l0 = '{r: hr, g: b3, b: b2};
          hold_r_d = b1;
          hold_g_d = b0;
          phase_d  = 2'd2;
          idx_d    = ix + 6'd1;
        end
        default: begin
          l0 = '{r: hr, g: hg, b: b3};
          l1 = '{r: b2, g: b1, b: b0};
          v1 = 1'b1;
          phase_d = 2'd0;
          idx_d   = ix + 6'd2;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q        <= 2'd0;
      idx_q          <= 6'd0;
      hold_r_q       <= 8'd0;
      hold_g_q       <= 8'd0;
      s1_v0          <= 1'b0;
      s1_v1          <= 1'b0;
      s1_done        <= 1'b0;
      s1_a0          <= 6'd0;
      s1_a1          <= 6'd0;
      s1_p0          <= '0;
      s1_p1          <= '0;
      s2_v0          <= 1'b0;
      s2_v1          <= 1'b0;
      s2_done        <= 1'b0;
      s2_a0          <= 6'd0;
      s2_a1          <= 6'd0;
      s2_c0          <= '0;
      s2_c1          <= '0;
      CC_wren0       <= 1'b0;
      CC_addr0       <= 6'd0;
      CC_Y0          <= '0;
      CC_Cb0         <= '0;
      CC_Cr0         <= '0;
      CC_wren1       <= 1'b0;
      CC_addr1       <= 6'd0;
      CC_Y1          <= '0;
      CC_Cb1         <= '0;
      CC_Cr1         <= '0;
      CC_block_done  <= 1'b0;
      CC_block_count <= 16'd0;
    end else begin
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      hold_r_q <= hold_r_d;
      hold_g_q <= hold_g_d;
      // S1: unpacked pixels
      s1_v0   <= v0;
      s1_v1   <= v1;
      s1_done <= v1 && (ix + 6'd1 == LastPx);
      s1_a0   <= ix;
      s1_a1   <= ix + 6'd1;
      s1_p0   <= l0;
      s1_p1   <= l1;
      // S2: weighted sums
      s2_v0   <= s1_v0;
      s2_v1   <= s1_v1;
      s2_done <= s1_done;
      s2_a0   <= s1_a0;
      s2_a1   <= s1_a1;
      s2_c0   <= convert(s1_p0);
      s2_c1   <= convert(s1_p1);
      // S3: shift, level shift Y, saturate
      CC_wren0      <= s2_v0;
      CC_addr0      <= s2_a0;
      CC_Y0         <= sat((s2_c0.y >>> 8) - 18'sd128);
      CC_Cb0        <= sat(s2_c0.cb >>> 8);
      CC_Cr0        <= sat(s2_c0.cr >>> 8);
      CC_wren1      <= s2_v1;
      CC_addr1      <= s2_a1;
      CC_Y1         <= sat((s2_c1.y >>> 8) - 18'sd128);
      CC_Cb1        <= sat(s2_c1.cb >>> 8);
      CC_Cr1        <= sat(s2_c1.cr >>> 8);
      CC_block_done <= s2_done;
      if (s2_done) CC_block_count <= CC_block_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ic_gb8_color_convert.sv
// Randomized bench for ic_gb8_color_convert: byte-queue reference model predicts every sample write
// (cycle, lane, address, values, block_done); each scenario task drains and compares its own writes.
module tb_ic_gb8_color_convert;

  logic        clk = 1'b0;
  logic        reset;
  logic        GB8_outputready;
  logic [31:0] GB8_data;
  logic        IC_frame_start;
  logic        CC_wren0, CC_wren1, CC_block_done;
  logic [5:0]  CC_addr0, CC_addr1;
  logic [7:0]  CC_Y0, CC_Cb0, CC_Cr0, CC_Y1, CC_Cb1, CC_Cr1;
  logic [15:0] CC_block_count;

  ic_gb8_color_convert dut (
    .clk(clk), .reset(reset), .GB8_outputready(GB8_outputready), .GB8_data(GB8_data),
    .IC_frame_start(IC_frame_start),
    .CC_wren0(CC_wren0), .CC_addr0(CC_addr0), .CC_Y0(CC_Y0), .CC_Cb0(CC_Cb0), .CC_Cr0(CC_Cr0),
    .CC_wren1(CC_wren1), .CC_addr1(CC_addr1), .CC_Y1(CC_Y1), .CC_Cb1(CC_Cb1), .CC_Cr1(CC_Cr1),
    .CC_block_done(CC_block_done), .CC_block_count(CC_block_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic       lane;
    logic [5:0] addr;
    logic [7:0] y, cb, cr;
    logic       done;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   stray = 0;
  wr_t  exp_q[$];
  wr_t  obs_q[$];
  int   m_bytes[$];
  int   m_px = 0;
  int   m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (!reset) begin
      if (CC_wren0) begin
        w = '{cyc: cyc, lane: 1'b0, addr: CC_addr0, y: CC_Y0, cb: CC_Cb0, cr: CC_Cr0, done: 1'b0};
        obs_q.push_back(w);
      end
      if (CC_wren1) begin
        w = '{cyc: cyc, lane: 1'b1, addr: CC_addr1, y: CC_Y1, cb: CC_Cb1, cr: CC_Cr1,
              done: CC_block_done};
        obs_q.push_back(w);
      end
      if ((CC_block_done && !CC_wren1) || (CC_wren1 && !CC_wren0)) stray++;
    end
  end

  function automatic logic [7:0] clamp8(input int v);
    int c;
    c = (v > 127) ? 127 : (v < -128) ? -128 : v;
    return c[7:0];
  endfunction

  function automatic int fdiv256(input int v);
    return $rtoi($floor(real'(v) / 256.0));
  endfunction

  // Reference: bytes accumulate in delivery order; every 3 bytes form a pixel written 3 cycles
  // after the word that completed it. Pixel 4k+3 goes to lane 1.
  task automatic model_word(input logic v, input logic [31:0] d, input logic fs);
    wr_t w;
    int  r, g, b;
    if (fs) begin
      m_bytes.delete();
      m_px = 0;
    end
    if (v) begin
      for (int i = 3; i >= 0; i--) m_bytes.push_back(int'((d >> (8 * i)) & 32'hFF));
      while (m_bytes.size() >= 3) begin
        r = m_bytes.pop_front();
        g = m_bytes.pop_front();
        b = m_bytes.pop_front();
        w.cyc  = cyc + 3;
        w.lane = (m_px % 4 == 3);
        w.addr = 6'(m_px);
        w.y    = clamp8(fdiv256(77 * r + 150 * g + 29 * b + 128) - 128);
        w.cb   = clamp8(fdiv256(-43 * r - 85 * g + 128 * b + 128));
        w.cr   = clamp8(fdiv256(128 * r - 107 * g - 21 * b + 128));
        w.done = (m_px == 63);
        exp_q.push_back(w);
        if (m_px == 63) m_cnt++;
        m_px = (m_px + 1) % 64;
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic fs);
    GB8_outputready = v;
    GB8_data        = d;
    IC_frame_start  = fs;
    model_word(v, d, fs);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (6) step(1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    GB8_outputready = 1'b0;
    GB8_data = 32'h0;
    IC_frame_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({CC_wren0, CC_wren1, CC_block_done, CC_addr0, CC_addr1, CC_Y0, CC_Cb0, CC_Cr0, CC_Y1,
         CC_Cb1, CC_Cr1, CC_block_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: outputs nonzero wren0=%b Y0=%h count=%h, want all 0",
               CC_wren0, CC_Y0, CC_block_count);
    end
    reset = 1'b0;
    repeat (4) step(1'b0, 32'h0, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: %0d writes without input, want 0", obs_q.size());
    end
  endtask

  task automatic test_white();
    wr_t e, o;
    int  n;
    n = cyc;
    repeat (3) step(1'b1, 32'hFFFF_FFFF, 1'b0);
    drain();
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL white_count: %0d writes, want 4", obs_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e || o.y !== 8'd127 || o.cb !== 8'd0 || o.cr !== 8'd0
          || o.cyc !== n + 3 + ((o.addr > 2) ? 2 : int'(o.addr))) begin
        errors++;
        $display("FAIL white_px: got %p want %p (Y=127 Cb=0 Cr=0)", o, e);
      end
    end
  endtask

  task automatic test_colors();
    wr_t e, o;
    int  ey[4]  = '{-51, -99, -128, -51};
    int  ecb[4] = '{-43, 127, 0, -43};
    int  ecr[4] = '{127, -21, 0, 127};
    int  i;
    // red, blue, black, red at pixels 4..7
    step(1'b1, 32'hFF00_0000, 1'b0);
    step(1'b1, 32'h00FF_0000, 1'b0);
    step(1'b1, 32'h00FF_0000, 1'b0);
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      i = int'(o.addr) - 4;
      checks++;
      if (o !== e || i < 0 || i > 3) begin
        errors++;
        $display("FAIL color_px: got %p want %p", o, e);
      end else if ($signed(o.y) != ey[i] || $signed(o.cb) != ecb[i] || $signed(o.cr) != ecr[i])
      begin
        errors++;
        $display("FAIL color_const: addr %0d got %0d/%0d/%0d want %0d/%0d/%0d", o.addr,
                 $signed(o.y), $signed(o.cb), $signed(o.cr), ey[i], ecb[i], ecr[i]);
      end
    end
    checks++;
    if (exp_q.size() != obs_q.size()) begin
      errors++;
      $display("FAIL color_count: %0d leftover writes, want %0d", obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    wr_t e, o;
    int  a = 0;
    int  dones = 0;
    for (int k = 0; k < 96; k++) step(1'b1, $urandom, k == 0);
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e || o.addr !== 6'(a)) begin
        errors++;
        $display("FAIL b2b_px: got %p want %p addr %0d", o, e, a);
      end
      if (o.done) dones++;
      a = (a + 1) % 64;
    end
    checks++;
    if (dones != 2 || CC_block_count !== 16'd2 || exp_q.size() != obs_q.size() || stray != 0) begin
      errors++;
      $display("FAIL b2b_blocks: dones=%0d count=%0d left=%0d/%0d stray=%0d want 2,2,0,0,0",
               dones, CC_block_count, obs_q.size(), exp_q.size(), stray);
    end
  endtask

  task automatic test_mid_reset();
    wr_t e, o;
    repeat (4) step(1'b1, $urandom | 32'h8080_8080, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({CC_wren0, CC_wren1, CC_block_done, CC_addr0, CC_addr1, CC_Y0, CC_Cb0, CC_Cr0, CC_Y1,
         CC_Cb1, CC_Cr1, CC_block_count} !== '0) begin
      errors++;
      $display("FAIL async_reset: wren0=%b addr0=%0d Y0=%h count=%0d, want all 0",
               CC_wren0, CC_addr0, CC_Y0, CC_block_count);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    m_bytes.delete();
    m_px = 0;
    m_cnt = 0;
    drain();
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_flush: %0d writes after release, want 0", obs_q.size());
    end
    repeat (3) step(1'b1, $urandom, 1'b0);
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL post_reset_px: got %p want %p", o, e);
      end
    end
  endtask

  task automatic test_gaps();
    wr_t e, o;
    for (int k = 0; k < 60; k++) begin
      while ($urandom_range(0, 2) == 0) step(1'b0, $urandom, 1'b0);
      step(1'b1, $urandom, 1'b0);
    end
    drain();
    checks++;
    if (exp_q.size() != obs_q.size() || CC_block_count !== 16'(m_cnt)) begin
      errors++;
      $display("FAIL gaps_count: writes %0d count %0d, want %0d and %0d", obs_q.size(),
               CC_block_count, exp_q.size(), m_cnt);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL gaps_px: got %p want %p", o, e);
      end
    end
  endtask

  task automatic test_frame_start();
    wr_t e, o;
    logic [15:0] cnt0;
    cnt0 = CC_block_count;
    step(1'b1, $urandom, 1'b0);
    step(1'b1, $urandom, 1'b1);
    step(1'b1, $urandom, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, $urandom, 1'b0);
    step(1'b1, $urandom, 1'b0);
    step(1'b1, $urandom, 1'b0);
    drain();
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL fs_px: got %p want %p", o, e);
      end
    end
    checks++;
    if (CC_block_count !== cnt0 || exp_q.size() != obs_q.size()) begin
      errors++;
      $display("FAIL fs_count: count %0d left %0d, want %0d and %0d", CC_block_count,
               obs_q.size(), cnt0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_white();
    test_colors();
    test_back_to_back();
    test_mid_reset();
    test_gaps();
    test_frame_start();
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL lane_rules: %0d stray done/wren1 cycles, want 0", stray);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

endmodule
